// File: rtl/button_led_arbiter.sv
// Shared-LED arbiter for N push buttons.
// Each raw button is synchronized, debounced and edge-detected. A debounced
// press latches a pending request. Requests are granted round-robin: the
// winner gets the LED for HOLD_CYCLES cycles, then a one-cycle gap and one
// idle cycle separate it from the next grant.
module button_led_arbiter #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         button,
   output logic                 led,
   output logic [$clog2(N)-1:0] owner,
   output logic                 owner_valid,
   output logic [N-1:0]         pending
);

   localparam int OW = $clog2(N);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      GAP
   } state_t;

   // Synchronizer and debounce state
   logic [N-1:0]         sync_meta;
   logic [N-1:0]         sync_level;
   logic [N-1:0]         db_level;
   logic [N-1:0][CW-1:0] db_cnt;
   logic [N-1:0]         db_accept;
   logic [N-1:0]         db_rise;

   // Arbiter state
   state_t               state;
   logic [OW-1:0]        last_owner;
   logic [HW-1:0]        hold_cnt;

   // Round-robin selection
   logic [N-1:0]         rot;
   int                   pick;
   int                   sum;
   logic [OW-1:0]        winner;
   logic                 grant;
   logic [N-1:0]         grant_mask;

   // Two-flop synchronizer on every raw button bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta  <= '0;
         sync_level <= '0;
      end else begin
         // NOTE: registers are always written with <= so every flop samples
         // the pre-edge value of its neighbours, whatever the block order.
         sync_meta  <= button;
         sync_level <= sync_meta;
      end
   end

   // A bit is accepted once it has differed from the debounced level for
   // DEBOUNCE_CYCLES consecutive samples; accepted rising levels are presses.
   always_comb begin
      // NOTE: every combinational output gets a value on every path,
      // otherwise synthesis infers a latch to hold the old value.
      db_accept = '0;
      for (int i = 0; i < N; i++) begin
         db_accept[i] = (sync_level[i] != db_level[i]) && (db_cnt[i] == DB_LAST);
      end
      db_rise = db_accept & sync_level;
   end

   // Per-bit debounce counter and debounced level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the counter array is small and must start at zero, so it is
         // reset element by element like any other register.
         for (int i = 0; i < N; i++) begin
            db_cnt[i] <= '0;
         end
         db_level <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (sync_level[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_accept[i]) begin
               db_level[i] <= sync_level[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Round-robin pick: rotate pending so bit 0 is the slot after last_owner,
   // take the lowest set bit and map it back to a button index.
   always_comb begin
      rot  = N'({pending, pending} >> (int'(last_owner) + 1));
      pick = 0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) begin
            pick = j;
         end
      end
      sum = int'(last_owner) + 1 + pick;
      if (sum >= N) begin
         sum = sum - N;
      end
      winner     = OW'(sum);
      grant      = (state == IDLE) && (|pending);
      grant_mask = grant ? (N'(1) << winner) : '0;
   end

   // Grant FSM with registered outputs; a new press wins over a grant clear
   // of the same bit on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         led         <= 1'b0;
         owner       <= '0;
         owner_valid <= 1'b0;
         last_owner  <= OW'(N - 1);
         hold_cnt    <= '0;
         pending     <= '0;
      end else begin
         pending <= (pending & ~grant_mask) | db_rise;
         case (state)
            IDLE: begin
               if (grant) begin
                  state       <= ON;
                  owner       <= winner;
                  last_owner  <= winner;
                  led         <= 1'b1;
                  owner_valid <= 1'b1;
                  hold_cnt    <= '0;
               end
            end
            ON: begin
               if (hold_cnt == HOLD_LAST) begin
                  state       <= GAP;
                  led         <= 1'b0;
                  owner_valid <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GAP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
